// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: widths, func3 size/sign
// encodings, FSM state type, request/context records and small helpers.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (see mem_access.sv).
package mem_pkg;

   localparam int XLEN = 64;
   localparam int STRB = XLEN / 8;
   localparam int OFFW = $clog2(STRB);

   // func3 access size/sign encodings (RV64 load/store)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_LDU = 3'b111;

   // func3[1:0] alone selects the access size
   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_ALU   = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } op_e;

   // Everything the data memory sees alongside dm_req
   typedef struct packed {
      logic            we;
      logic [STRB-1:0] wstrb;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } dm_req_t;

   // What the load path must remember while the access is outstanding
   typedef struct packed {
      logic            load;
      logic [2:0]      func3;
      logic [OFFW-1:0] offset;
   } ld_ctx_t;

   // A store wins when both mem_rw and is_load are set
   function automatic op_e decode_op(input logic mem_rw, input logic is_load);
      if (mem_rw)
         return OP_STORE;
      if (is_load)
         return OP_LOAD;
      return OP_ALU;
   endfunction

   // Byte-lane mask for an access of the given size at offset 0
   function automatic logic [STRB-1:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 8'h01;
         SZ_HALF: return 8'h03;
         SZ_WORD: return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   // True when the byte offset is not a multiple of the access size
   function automatic logic misaligned(input logic [OFFW-1:0] offset,
                                       input logic [1:0]      size);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return offset[0];
         SZ_WORD: return |offset[1:0];
         default: return |offset;
      endcase
   endfunction

   // Doubleword-aligned request; lanes past the doubleword end are simply
   // shifted out, so a crossing access is masked rather than split.
   function automatic dm_req_t build_req(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] data,
                                         input logic [1:0]      size,
                                         input logic            store);
      dm_req_t         r;
      logic [OFFW-1:0] off;
      off     = addr[OFFW-1:0];
      r.addr  = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      r.we    = store;
      r.wstrb = store ? (size_mask(size) << off) : '0;
      r.wdata = store ? (data << {off, 3'b000}) : '0;
      return r;
   endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// load_extend: combinational load alignment and sign/zero extension.
// Moves the addressed bytes of the read doubleword to bit 0 and extends
// them according to func3; doubleword encodings return rdata unchanged.
module load_extend
   import mem_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [OFFW-1:0] offset,
   input  logic [2:0]      func3,
   output logic [XLEN-1:0] value
);

   logic [XLEN-1:0] shifted;

   // Align the selected bytes to lane 0, then extend by access type
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through the case leaves it unassigned (which infers a latch).
      value   = rdata;
      shifted = rdata >> {offset, 3'b000};
      case (func3)
         F3_LB:   value = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         F3_LH:   value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LW:   value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_LBU:  value = {{(XLEN-8){1'b0}},         shifted[7:0]};
         F3_LHU:  value = {{(XLEN-16){1'b0}},        shifted[15:0]};
         F3_LWU:  value = {{(XLEN-32){1'b0}},        shifted[31:0]};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage between EX and write-back.
// ALU results pass through with one cycle of latency; loads and stores
// issue a single doubleword request to data memory and wait for dm_ack.
// Optional feature: define MEM_MISALIGN_CHECK_EN to suppress misaligned
// accesses and report them on the extra 'misalign' output.
module mem_access
   import mem_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] result,
   input  logic [XLEN-1:0] store_data,
   input  logic [2:0]      func3,
   input  logic            mem_rw,
   input  logic            is_load,
   output logic            dm_req,
   output logic            dm_we,
   output logic [XLEN-1:0] dm_addr,
   output logic [XLEN-1:0] dm_wdata,
   output logic [STRB-1:0] dm_wstrb,
   input  logic            dm_ack,
   input  logic [XLEN-1:0] dm_rdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_data,
   output logic            stall
`ifdef MEM_MISALIGN_CHECK_EN
   ,
   output logic            misalign
`endif
);

   state_e          state;
   state_e          state_next;
   op_e             op;
   logic            accept;
   logic            bad_align;
   logic            issue;
   dm_req_t         req_next;
   dm_req_t         req_q;
   ld_ctx_t         ctx_q;
   logic [XLEN-1:0] load_value;
   logic [XLEN-1:0] load_data_q;

   assign op       = decode_op(mem_rw, is_load);
   assign accept   = in_valid & in_ready;
   assign req_next = build_req(result, store_data, func3[1:0], op == OP_STORE);

`ifdef MEM_MISALIGN_CHECK_EN
   assign bad_align = misaligned(result[OFFW-1:0], func3[1:0]);
`else
   assign bad_align = 1'b0;
`endif

   // A memory op goes to REQ unless the alignment check rejects it
   assign issue = accept & (op != OP_ALU) & ~bad_align;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: reset is asynchronous, so dm_req (decoded from state) drops the
      // moment rst falls, abandoning any access still in flight.
      if (!rst)
         state <= IDLE;
      else
         // NOTE: sequential state always uses non-blocking assignment so
         // every flop samples pre-edge values regardless of block order.
         state <= state_next;
   end

   // FSM next-state logic; dm_ack only matters in REQ
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (issue) state_next = REQ;
         REQ:     if (dm_ack) state_next = ctx_q.load ? RESP : IDLE;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: handshake and request strobe are pure state decodes
   always_comb begin
      in_ready = (state == IDLE);
      dm_req   = (state == REQ);
      stall    = in_valid & (state != IDLE);
   end

   // Request fields are captured at accept and held for the whole REQ phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q <= '0;
         ctx_q <= '0;
      end else if (issue) begin
         req_q <= req_next;
         ctx_q <= '{load:   (op == OP_LOAD),
                    func3:  func3,
                    offset: result[OFFW-1:0]};
      end
   end

   assign dm_we    = req_q.we;
   assign dm_addr  = req_q.addr;
   assign dm_wdata = req_q.wdata;
   assign dm_wstrb = req_q.wstrb;

   load_extend u_load_extend (
      .rdata  (dm_rdata),
      .offset (ctx_q.offset),
      .func3  (ctx_q.func3),
      .value  (load_value)
   );

   // Latch the extracted load value on the completing dm_ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         load_data_q <= '0;
      else if ((state == REQ) && dm_ack && ctx_q.load)
         load_data_q <= load_value;
   end

   // Registered write-back: ALU result after accept, load data out of RESP.
   // The two sources never coincide because in_ready is low in RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid <= 1'b0;
         wb_data  <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (accept && (op == OP_ALU)) begin
            wb_valid <= 1'b1;
            wb_data  <= result;
         end else if (state == RESP) begin
            wb_valid <= 1'b1;
            wb_data  <= load_data_q;
         end
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   // One-cycle flag for a rejected misaligned memory op
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         misalign <= 1'b0;
      else
         misalign <= accept & (op != OP_ALU) & bad_align;
   end
`endif

endmodule
